// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_SEL_HOLD = 2'd0,
      PC_SEL_INC  = 2'd1,
      PC_SEL_TGT  = 2'd2
   } pc_sel_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned PC_INCR  = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / +4 / word-aligned redirect selection.
module fetch_pc_gen
   import inst_fetch_pkg::*;
#(
   parameter int unsigned                    WIDTH_DATA_LENGTH = 32,
   parameter logic [WIDTH_DATA_LENGTH-1:0]   RESET_PC          = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  pc_sel_e                      sel_i,
   input  logic [WIDTH_DATA_LENGTH-1:0] target_i,
   output logic [WIDTH_DATA_LENGTH-1:0] pc_o
);

   logic [WIDTH_DATA_LENGTH-1:0] pc_q;
   logic [WIDTH_DATA_LENGTH-1:0] pc_d;

   // Redirect targets are forced onto a word boundary; increment wraps naturally.
   always_comb begin
      pc_d = pc_q;
      case (sel_i)
         PC_SEL_INC:  pc_d = pc_q + WIDTH_DATA_LENGTH'(PC_INCR);
         PC_SEL_TGT:  pc_d = target_i & ~WIDTH_DATA_LENGTH'(3);
         default:     pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: branch-wait FSM, IF/ID register, PC generator.
// Optional bubble counter output Bubble_Cnt enabled by FETCH_PERF_CNT_EN.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned                    WIDTH_DATA_LENGTH = 32,
   parameter logic [WIDTH_DATA_LENGTH-1:0]   RESET_PC          = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [WIDTH_DATA_LENGTH-1:0] Imem_Addr,
   input  logic [WIDTH_DATA_LENGTH-1:0] Imem_Data,
   input  logic                         Stall,
   input  logic                         Br_Dectected,
   input  logic                         Br_Resolved,
   input  logic                         Br_Taken,
   input  logic [WIDTH_DATA_LENGTH-1:0] Br_Target,
   output logic [WIDTH_DATA_LENGTH-1:0] Inst_D,
   output logic [WIDTH_DATA_LENGTH-1:0] PC_D,
   output logic                         Valid_D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                  Bubble_Cnt
`endif
);

   localparam logic [WIDTH_DATA_LENGTH-1:0] NOP_W = WIDTH_DATA_LENGTH'(NOP_INST);

   fetch_state_e                 state_q, state_d;
   logic [WIDTH_DATA_LENGTH-1:0] inst_q,  inst_d;
   logic [WIDTH_DATA_LENGTH-1:0] pcd_q,   pcd_d;
   logic                         valid_q, valid_d;
   pc_sel_e                      pc_sel;
   logic [WIDTH_DATA_LENGTH-1:0] pc;

   fetch_pc_gen #(
      .WIDTH_DATA_LENGTH (WIDTH_DATA_LENGTH),
      .RESET_PC          (RESET_PC)
   ) u_pc_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel_i    (pc_sel),
      .target_i (Br_Target),
      .pc_o     (pc)
   );

   // Next-state, IF/ID and PC select; Stall beats detection so it recurs later.
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      pcd_d   = pcd_q;
      valid_d = valid_q;
      pc_sel  = PC_SEL_HOLD;
      case (state_q)
         RUN: begin
            if (!Stall) begin
               pcd_d = pc;
               if (Br_Dectected) begin
                  inst_d  = NOP_W;
                  valid_d = 1'b0;
                  state_d = BR_WAIT;
               end else begin
                  inst_d  = Imem_Data;
                  valid_d = 1'b1;
                  pc_sel  = PC_SEL_INC;
               end
            end
         end
         BR_WAIT: begin
            inst_d  = NOP_W;
            valid_d = 1'b0;
            if (Br_Resolved) begin
               state_d = RUN;
               pc_sel  = Br_Taken ? PC_SEL_TGT : PC_SEL_HOLD;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         inst_q  <= NOP_W;
         pcd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         pcd_q   <= pcd_d;
         valid_q <= valid_d;
      end
   end

   assign Imem_Addr = pc;
   assign Inst_D    = inst_q;
   assign PC_D      = pcd_q;
   assign Valid_D   = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic        bubble_c;
   logic [31:0] cnt_q, cnt_d;

   // A bubble is written on every detect edge and every BR_WAIT edge.
   assign bubble_c = (state_q == BR_WAIT) ||
                     ((state_q == RUN) && !Stall && Br_Dectected);

   always_comb begin
      cnt_d = cnt_q;
      if (bubble_c && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign Bubble_Cnt = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational instruction memory model.
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] BEQ = 32'h0020_8463;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        br_det;
   logic        br_res;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] inst_d;
   logic [31:0] pc_d;
   logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   inst_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Imem_Addr    (imem_addr),
      .Imem_Data    (imem_data),
      .Stall        (stall),
      .Br_Dectected (br_det),
      .Br_Resolved  (br_res),
      .Br_Taken     (br_taken),
      .Br_Target    (br_target),
      .Inst_D       (inst_d),
      .PC_D         (pc_d),
      .Valid_D      (valid_d)
`ifdef FETCH_PERF_CNT_EN
      ,
      .Bubble_Cnt   (bubble_cnt)
`endif
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h10) return BEQ;
      return {a[11:0], 8'h00, 12'h093};
   endfunction

   assign imem_data = mem(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; br_det = 0; br_res = 0; br_taken = 0; br_target = 32'h0;
   endtask

   // Reset, then fetch sequentially until the BEQ at 0x10 sits in Inst_D.
   task automatic fetch_to_beq();
      idle_inputs();
      rst_n = 0;
      #3;
      rst_n = 1;
      for (int i = 0; i < 5; i++) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #12;
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
      total++; if (inst_d !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst_d, NOP); end
      total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL reset_pcd got=%h exp=%h", pc_d, 32'h0); end
      total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (bubble_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
`endif
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (inst_d !== mem(32'(i * 4))) begin bad++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, inst_d, mem(32'(i * 4))); end
         total++; if (pc_d !== 32'(i * 4)) begin bad++; $display("FAIL seq_pcd[%0d] got=%h exp=%h", i, pc_d, 32'(i * 4)); end
         total++; if (valid_d !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, valid_d); end
      end
      total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'hC); end
   endtask

   task automatic test_stall();
      fetch_to_beq();
      rst_n = 0; #2; rst_n = 1;
      tick(); tick();
      stall = 1;
      tick(); tick();
      total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h exp=%h", imem_addr, 32'h8); end
      total++; if (inst_d !== mem(32'h4) || pc_d !== 32'h4) begin bad++; $display("FAIL stall_hold got=%h/%h exp=%h/%h", inst_d, pc_d, mem(32'h4), 32'h4); end
      stall = 0;
      tick();
      total++; if (inst_d !== mem(32'h8) || pc_d !== 32'h8 || valid_d !== 1'b1) begin bad++; $display("FAIL stall_resume got=%h/%h/%b exp=%h/%h/1", inst_d, pc_d, valid_d, mem(32'h8), 32'h8); end
   endtask

   task automatic test_branch_taken();
      fetch_to_beq();
      total++; if (inst_d !== BEQ || pc_d !== 32'h10 || imem_addr !== 32'h14) begin bad++; $display("FAIL beq_fetch got=%h/%h/%h exp=%h/10/14", inst_d, pc_d, imem_addr, BEQ); end
      stall = 1; br_det = 1;
      tick();
      total++; if (inst_d !== BEQ || valid_d !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL stall_prio got=%h/%b/%h exp=%h/1/14", inst_d, valid_d, imem_addr, BEQ); end
      stall = 0;
      tick();
      br_det = 0;
      total++; if (inst_d !== NOP || valid_d !== 1'b0 || pc_d !== 32'h14 || imem_addr !== 32'h14) begin bad++; $display("FAIL tk_bubble1 got=%h/%b/%h/%h exp=%h/0/14/14", inst_d, valid_d, pc_d, imem_addr, NOP); end
      tick();
      total++; if (inst_d !== NOP || valid_d !== 1'b0 || imem_addr !== 32'h14) begin bad++; $display("FAIL tk_bubble2 got=%h/%b/%h exp=%h/0/14", inst_d, valid_d, imem_addr, NOP); end
      br_res = 1; br_taken = 1; br_target = 32'h40;
      tick();
      br_res = 0; br_taken = 0;
      total++; if (imem_addr !== 32'h40 || valid_d !== 1'b0) begin bad++; $display("FAIL tk_redirect got=%h/%b exp=40/0", imem_addr, valid_d); end
      tick();
      total++; if (inst_d !== mem(32'h40) || pc_d !== 32'h40 || valid_d !== 1'b1) begin bad++; $display("FAIL tk_target got=%h/%h/%b exp=%h/40/1", inst_d, pc_d, valid_d, mem(32'h40)); end
   endtask

   task automatic test_branch_not_taken();
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] c0;
`endif
      fetch_to_beq();
`ifdef FETCH_PERF_CNT_EN
      c0 = bubble_cnt;
`endif
      br_det = 1;
      tick();
      br_det = 0; stall = 1;
      tick();
      total++; if (valid_d !== 1'b0 || imem_addr !== 32'h14) begin bad++; $display("FAIL nt_wait got=%b/%h exp=0/14", valid_d, imem_addr); end
      stall = 0; br_res = 1; br_taken = 0; br_target = 32'h80;
      tick();
      br_res = 0;
      total++; if (imem_addr !== 32'h14 || inst_d !== NOP) begin bad++; $display("FAIL nt_resolve got=%h/%h exp=14/%h", imem_addr, inst_d, NOP); end
      tick();
      total++; if (inst_d !== mem(32'h14) || pc_d !== 32'h14 || valid_d !== 1'b1) begin bad++; $display("FAIL nt_resume got=%h/%h/%b exp=%h/14/1", inst_d, pc_d, valid_d, mem(32'h14)); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (bubble_cnt - c0 !== 32'd3) begin bad++; $display("FAIL nt_bubbles got=%0d exp=3", bubble_cnt - c0); end
`endif
   endtask

   task automatic test_align_wrap();
      br_det = 1;
      tick();
      br_det = 0; br_res = 1; br_taken = 1; br_target = 32'h43;
      tick();
      br_res = 0; br_taken = 0;
      total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL align got=%h exp=40", imem_addr); end
      br_det = 1;
      tick();
      br_det = 0; br_res = 1; br_taken = 1; br_target = 32'hFFFF_FFFC;
      tick();
      br_res = 0; br_taken = 0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_tgt got=%h exp=fffffffc", imem_addr); end
      tick();
      total++; if (imem_addr !== 32'h0 || pc_d !== 32'hFFFF_FFFC || inst_d !== mem(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap got=%h/%h/%h exp=0/fffffffc/%h", imem_addr, pc_d, inst_d, mem(32'hFFFF_FFFC)); end
   endtask

   task automatic test_reset_mid();
      fetch_to_beq();
      br_det = 1;
      tick();
      br_det = 0;
      #2;
      rst_n = 0;
      #1;
      total++; if (imem_addr !== 32'h0 || inst_d !== NOP || pc_d !== 32'h0 || valid_d !== 1'b0) begin bad++; $display("FAIL rst_mid got=%h/%h/%h/%b exp=0/%h/0/0", imem_addr, inst_d, pc_d, valid_d, NOP); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (bubble_cnt !== 32'h0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", bubble_cnt); end
`endif
      rst_n = 1;
      br_res = 1; br_taken = 1; br_target = 32'h80;
      tick();
      br_res = 0; br_taken = 0;
      total++; if (inst_d !== mem(32'h0) || pc_d !== 32'h0 || valid_d !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL rst_restart got=%h/%h/%b/%h exp=%h/0/1/4", inst_d, pc_d, valid_d, imem_addr, mem(32'h0)); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch_taken();
      test_branch_not_taken();
      test_align_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. The IF/ID instruction feeds the branch detector, which returns Br_Dectected. On a detected control-transfer instruction, the block inserts bubbles and holds the PC until the execute stage resolves the branch. It then redirects to the target or continues sequentially.

## Interface
- WIDTH_DATA_LENGTH, 32, instruction/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Imem_Addr  output  WIDTH_DATA_LENGTH  instruction-memory address (= PC, combinational)
- Imem_Data  input  WIDTH_DATA_LENGTH  instruction word at Imem_Addr, same cycle (combinational memory)
- Stall  input  1  hazard stall from decode; hold PC and IF/ID
- Br_Dectected  input  1  branch detector output for the current Inst_D
- Br_Resolved  input  1  one-cycle pulse from execute: pending branch resolved
- Br_Taken  input  1  qualifies Br_Resolved: redirect to Br_Target
- Br_Target  input  WIDTH_DATA_LENGTH  redirect address
- Inst_D  output  WIDTH_DATA_LENGTH  IF/ID instruction (drives branch detector)
- PC_D  output  WIDTH_DATA_LENGTH  IF/ID PC of Inst_D
- Valid_D  output  1  Inst_D is a real instruction, not a bubble

## Operation
- Two states: RUN and BR_WAIT. Reset state is RUN.
- RUN, Stall=1: PC, Inst_D, PC_D and Valid_D hold. Stall has priority over Br_Dectected, so the detection recurs on the next cycle.
- RUN, Stall=0, Br_Dectected=0: Inst_D<=Imem_Data, PC_D<=PC, Valid_D<=1, PC<=PC+4.
- RUN, Stall=0, Br_Dectected=1:
  - the instruction at PC is discarded;
  - Inst_D<=NOP (32'h0000_0013), Valid_D<=0, PC_D<=PC;
  - PC holds; state goes to BR_WAIT.
- BR_WAIT, Br_Resolved=0: bubble inserted (Inst_D=NOP, Valid_D=0), PC holds. Stall is ignored.
- BR_WAIT, Br_Resolved=1:
  - bubble inserted;
  - PC<=Br_Target with bits [1:0] forced to 00 if Br_Taken, else PC holds;
  - state goes to RUN.
- Br_Resolved in RUN is ignored.
- PC arithmetic is modulo 2^WIDTH_DATA_LENGTH: 32'hFFFF_FFFC + 4 wraps to 0.
- A NOP in Inst_D never triggers Br_Dectected, so bubbles cannot self-trigger.
- Reset asserted mid-operation: all state returns to reset values immediately, and any pending branch is dropped.

## Timing
- Reset values: PC=RESET_PC, Imem_Addr=RESET_PC, Inst_D=NOP, PC_D=0, Valid_D=0, state RUN.
- Fetch latency: an instruction presented at Imem_Addr in cycle N appears on Inst_D in cycle N+1.
- Branch penalty: the branch is in Inst_D in cycle N. One bubble enters in N+1, plus one per BR_WAIT cycle including the resolve cycle. The first post-branch instruction appears in Inst_D two cycles after the Br_Resolved edge.
- Imem_Addr is combinational from the PC register. All other outputs are registered.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output Bubble_Cnt (32 bits).
  - Increments on each edge where a bubble is written into IF/ID.
  - Saturates at 32'hFFFF_FFFF; reset value 0.
- FETCH_PERF_CNT_EN undefined: Bubble_Cnt port and counter are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - fetch-state enum (RUN, BR_WAIT);
  - NOP constant 32'h0000_0013;
  - PC increment constant 4.
- One sub-module, fetch_pc_gen: the PC register with next-PC mux (hold / +4 / target with [1:0] cleared) and RESET_PC.
- The top level holds the FSM, the IF/ID register and the optional counter.

## Test plan
- Reset release with RESET_PC=0 and sequential ADDIs at 0,4,8: Inst_D shows them in consecutive cycles, PC_D=0,4,8, Valid_D=1.
- Stall=1 for 2 cycles at PC=8: Imem_Addr stays 8, Inst_D/PC_D unchanged. After release, fetch resumes at 8.
- BEQ at 0x10 with Br_Dectected=1, Br_Resolved+Br_Taken pulse 2 cycles later, Br_Target=0x40: bubbles appear, Imem_Addr=0x14 held, then 0x40. Inst_D from 0x40 has PC_D=0x40.
- Same BEQ resolved not-taken: fetch resumes at 0x14. Bubble count is 3 with FETCH_PERF_CNT_EN.
- Br_Target=0x43 taken: Imem_Addr=0x40. PC at 0xFFFF_FFFC advancing: Imem_Addr wraps to 0.
- rst_n asserted during BR_WAIT: outputs return to reset values immediately. After release, fetch restarts at RESET_PC in RUN.
